// File: rtl/rope_step_scheduler.sv
// rope_step_scheduler
// Per-frame sequencer for the rope physics array. On frame_start it latches the
// mouse anchor. It then issues one integrate step and RELAX_PASSES relax steps,
// and waits for every core to acknowledge each step. After the last step it
// copies the settled node positions into the back snapshot bank and swaps
// banks, so the renderer always reads a complete frame.
//
// Ports
//   clk, reset            system clock, async active-high reset
//   frame_start           vsync pulse, one cycle per frame
//   in_mouse_x/y          mouse position in pixels (10 bit)
//   core_done             per-core step-complete pulses
//   nodes_x/y             live node coordinates, node k at [10k+9:10k]
//   core_step/core_phase  step issue pulse and phase (0 integrate, 1 relax)
//   mouse_x/y             latched anchor, fixed point {10'b0, px, 12'b0}
//   rd_idx, rd_x/y        renderer read port on the front bank, 1-cycle latency
//   busy                  FSM not idle
//   frame_ready           pulses in the cycle the new front bank takes effect
//   overrun_cnt           saturating count of dropped frame_start pulses
//   timeout_err           sticky, set when a step is not acknowledged in time
//
// state  | meaning
// IDLE   | waiting for frame_start
// LATCH  | capture mouse anchor, reset pass counter and phase
// ISSUE  | pulse core_step with current phase, restart done tracking
// WAIT   | collect core_done bits, watch the acknowledge timer
// COPY   | copy one node per cycle into the back bank
// SWAP   | toggle the front bank, frame_ready follows

module rope_step_scheduler #(
   parameter int CORES          = 4,
   parameter int NODES_PER_CORE = 5,
   parameter int RELAX_PASSES   = 3,
   parameter int TIMEOUT        = 1023
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        frame_start,
   input  logic [9:0]                                  in_mouse_x,
   input  logic [9:0]                                  in_mouse_y,
   input  logic [CORES-1:0]                            core_done,
   input  logic [CORES*NODES_PER_CORE*10-1:0]          nodes_x,
   input  logic [CORES*NODES_PER_CORE*10-1:0]          nodes_y,
   output logic                                        core_step,
   output logic                                        core_phase,
   output logic [31:0]                                 mouse_x,
   output logic [31:0]                                 mouse_y,
   input  logic [$clog2(CORES*NODES_PER_CORE)-1:0]     rd_idx,
   output logic [9:0]                                  rd_x,
   output logic [9:0]                                  rd_y,
   output logic                                        busy,
   output logic                                        frame_ready,
   output logic [7:0]                                  overrun_cnt,
   output logic                                        timeout_err
);

   localparam int N      = CORES * NODES_PER_CORE;
   localparam int IDX_W  = $clog2(N);
   localparam int TMR_W  = $clog2(TIMEOUT + 1);
   localparam int PASS_W = $clog2(RELAX_PASSES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_COPY, S_SWAP
   } state_t;

   state_t             state_q, state_d;
   logic               phase_q, phase_d;
   logic [PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
   logic [CORES-1:0]   done_seen_q, done_seen_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [IDX_W-1:0]   cpy_idx_q, cpy_idx_d;
   logic               front_q, front_d;
   logic [9:0]         bank_x_q [2][N];
   logic [9:0]         bank_x_d [2][N];
   logic [9:0]         bank_y_q [2][N];
   logic [9:0]         bank_y_d [2][N];

   logic               core_step_q, core_step_d;
   logic               core_phase_q, core_phase_d;
   logic [31:0]        mouse_x_q, mouse_x_d;
   logic [31:0]        mouse_y_q, mouse_y_d;
   logic [9:0]         rd_x_q, rd_x_d;
   logic [9:0]         rd_y_q, rd_y_d;
   logic               busy_q, busy_d;
   logic               frame_ready_q, frame_ready_d;
   logic [7:0]         overrun_cnt_q, overrun_cnt_d;
   logic               timeout_err_q, timeout_err_d;

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      pass_cnt_d    = pass_cnt_q;
      done_seen_d   = done_seen_q;
      timer_d       = timer_q;
      cpy_idx_d     = cpy_idx_q;
      front_d       = front_q;
      bank_x_d      = bank_x_q;
      bank_y_d      = bank_y_q;
      mouse_x_d     = mouse_x_q;
      mouse_y_d     = mouse_y_q;
      overrun_cnt_d = overrun_cnt_q;
      timeout_err_d = timeout_err_q;

      // A frame_start that cannot be honoured is only counted; the FSM keeps going.
      if (frame_start && (state_q != S_IDLE) && (overrun_cnt_q != 8'hFF))
         overrun_cnt_d = overrun_cnt_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (frame_start)
               state_d = S_LATCH;
         end
         S_LATCH: begin
            mouse_x_d  = {10'b0, in_mouse_x, 12'b0};
            mouse_y_d  = {10'b0, in_mouse_y, 12'b0};
            pass_cnt_d = '0;
            phase_d    = 1'b0;
            state_d    = S_ISSUE;
         end
         S_ISSUE: begin
            done_seen_d = '0;
            timer_d     = TMR_W'(TIMEOUT);
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            done_seen_d = done_seen_q | core_done;
            timer_d     = timer_q - TMR_W'(1);
            if (&done_seen_d) begin
               if (!phase_q) begin
                  phase_d    = 1'b1;
                  pass_cnt_d = '0;
                  state_d    = S_ISSUE;
               end else if (int'(pass_cnt_q) < RELAX_PASSES - 1) begin
                  pass_cnt_d = pass_cnt_q + PASS_W'(1);
                  state_d    = S_ISSUE;
               end else begin
                  cpy_idx_d = '0;
                  state_d   = S_COPY;
               end
            end else if (timer_q == TMR_W'(1)) begin
               // Terminal count: TIMEOUT wait cycles have elapsed without completion.
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end
         end
         S_COPY: begin
            bank_x_d[!front_q][cpy_idx_q] = nodes_x[cpy_idx_q*10 +: 10];
            bank_y_d[!front_q][cpy_idx_q] = nodes_y[cpy_idx_q*10 +: 10];
            if (cpy_idx_q == IDX_W'(N - 1)) begin
               cpy_idx_d = '0;
               state_d   = S_SWAP;
            end else begin
               cpy_idx_d = cpy_idx_q + IDX_W'(1);
            end
         end
         S_SWAP: begin
            front_d = !front_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so core_step lines up with ISSUE.
      core_step_d   = (state_d == S_ISSUE);
      core_phase_d  = (state_d == S_ISSUE) ? phase_d : core_phase_q;
      busy_d        = (state_d != S_IDLE);
      frame_ready_d = (state_q == S_SWAP);

      // Reads use the current front, so a read during SWAP still sees the old bank.
      rd_x_d = '0;
      rd_y_d = '0;
      if (int'(rd_idx) < N) begin
         rd_x_d = bank_x_q[front_q][rd_idx];
         rd_y_d = bank_y_q[front_q][rd_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         phase_q       <= 1'b0;
         pass_cnt_q    <= '0;
         done_seen_q   <= '0;
         timer_q       <= '0;
         cpy_idx_q     <= '0;
         front_q       <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
               bank_x_q[b][i] <= '0;
               bank_y_q[b][i] <= '0;
            end
         end
         core_step_q   <= 1'b0;
         core_phase_q  <= 1'b0;
         mouse_x_q     <= '0;
         mouse_y_q     <= '0;
         rd_x_q        <= '0;
         rd_y_q        <= '0;
         busy_q        <= 1'b0;
         frame_ready_q <= 1'b0;
         overrun_cnt_q <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         pass_cnt_q    <= pass_cnt_d;
         done_seen_q   <= done_seen_d;
         timer_q       <= timer_d;
         cpy_idx_q     <= cpy_idx_d;
         front_q       <= front_d;
         bank_x_q      <= bank_x_d;
         bank_y_q      <= bank_y_d;
         core_step_q   <= core_step_d;
         core_phase_q  <= core_phase_d;
         mouse_x_q     <= mouse_x_d;
         mouse_y_q     <= mouse_y_d;
         rd_x_q        <= rd_x_d;
         rd_y_q        <= rd_y_d;
         busy_q        <= busy_d;
         frame_ready_q <= frame_ready_d;
         overrun_cnt_q <= overrun_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign core_step   = core_step_q;
   assign core_phase  = core_phase_q;
   assign mouse_x     = mouse_x_q;
   assign mouse_y     = mouse_y_q;
   assign rd_x        = rd_x_q;
   assign rd_y        = rd_y_q;
   assign busy        = busy_q;
   assign frame_ready = frame_ready_q;
   assign overrun_cnt = overrun_cnt_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rope_step_scheduler.sv
// Testbench for rope_step_scheduler. Core responders answer each step after a
// per-core latency; a reference model derives step times, frame_ready timing,
// overrun counts and snapshot contents from the frame rules.

module tb_rope_step_scheduler;

   localparam int CORES = 4;
   localparam int NPC   = 5;
   localparam int RELAX = 3;
   localparam int TMO   = 1023;
   localparam int N     = CORES * NPC;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               frame_start = 1'b0;
   logic [9:0]         in_mouse_x = '0;
   logic [9:0]         in_mouse_y = '0;
   logic [CORES-1:0]   core_done = '0;
   logic [N*10-1:0]    nodes_x = '0;
   logic [N*10-1:0]    nodes_y = '0;
   logic [4:0]         rd_idx = '0;
   logic               core_step, core_phase;
   logic [31:0]        mouse_x, mouse_y;
   logic [9:0]         rd_x, rd_y;
   logic               busy, frame_ready, timeout_err;
   logic [7:0]         overrun_cnt;

   rope_step_scheduler #(
      .CORES(CORES), .NODES_PER_CORE(NPC), .RELAX_PASSES(RELAX), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .in_mouse_x(in_mouse_x), .in_mouse_y(in_mouse_y),
      .core_done(core_done), .nodes_x(nodes_x), .nodes_y(nodes_y),
      .core_step(core_step), .core_phase(core_phase),
      .mouse_x(mouse_x), .mouse_y(mouse_y),
      .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
      .busy(busy), .frame_ready(frame_ready),
      .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // event log, sampled mid-cycle
   int   step_t[$];
   int   step_ph[$];
   int   ready_t[$];
   int   tmo_t[$];
   logic tmo_prev = 1'b0;

   always @(negedge clk) begin
      if (core_step === 1'b1) begin
         step_t.push_back(cyc);
         step_ph.push_back(int'(core_phase));
      end
      if (frame_ready === 1'b1) ready_t.push_back(cyc);
      if (timeout_err === 1'b1 && tmo_prev !== 1'b1) tmo_t.push_back(cyc);
      tmo_prev = timeout_err;
   end

   task automatic clear_log();
      step_t.delete();
      step_ph.delete();
      ready_t.delete();
      tmo_t.delete();
   endtask

   // core responders: lat[c] cycles after a step (negative = never answer)
   int lat[CORES];
   int due[CORES];
   bit dbl0  = 1'b0;
   bit early = 1'b0;
   bit stray = 1'b0;

   initial begin
      for (int c = 0; c < CORES; c++) begin
         lat[c] = 1;
         due[c] = -100;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int c = 0; c < CORES; c++) begin
            if (core_step === 1'b1 && lat[c] > 0) due[c] = cyc + lat[c];
            core_done[c] = (due[c] == cyc)
                        || (c == 0 && dbl0 && due[c] + 1 == cyc)
                        || (early && core_step === 1'b1)
                        || (stray && busy === 1'b0 && $urandom_range(0, 1) == 1);
         end
      end
   end

   // reference model of node inputs and the renderer-visible front bank
   logic [9:0] nx[N];
   logic [9:0] ny[N];
   logic [9:0] fx[N];
   logic [9:0] fy[N];

   task automatic drive_nodes(input bit pattern);
      for (int k = 0; k < N; k++) begin
         if (pattern) begin
            nx[k] = 10'(k + 10);
            ny[k] = 10'(2 * k);
         end else begin
            nx[k] = 10'($urandom_range(0, 1023));
            ny[k] = 10'($urandom_range(0, 1023));
         end
         nodes_x[k*10 +: 10] = nx[k];
         nodes_y[k*10 +: 10] = ny[k];
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < N; k++) begin
         fx[k] = '0;
         fy[k] = '0;
      end
   endtask

   task automatic model_publish();
      for (int k = 0; k < N; k++) begin
         fx[k] = nx[k];
         fy[k] = ny[k];
      end
   endtask

   task automatic check_read(input int idx, input string tag);
      logic [9:0] ex, ey;
      ex = '0;
      ey = '0;
      if (idx < N) begin
         ex = fx[idx];
         ey = fy[idx];
      end
      rd_idx = 5'(idx);
      tick();
      check($sformatf("%s rd_x[%0d]", tag, idx), 32'(rd_x), 32'(ex));
      check($sformatf("%s rd_y[%0d]", tag, idx), 32'(rd_y), 32'(ey));
   endtask

   task automatic check_zero(input string tag);
      check({tag, " core_step"},   32'(core_step),   0);
      check({tag, " core_phase"},  32'(core_phase),  0);
      check({tag, " mouse_x"},     mouse_x,          0);
      check({tag, " mouse_y"},     mouse_y,          0);
      check({tag, " rd_x"},        32'(rd_x),        0);
      check({tag, " rd_y"},        32'(rd_y),        0);
      check({tag, " busy"},        32'(busy),        0);
      check({tag, " frame_ready"}, 32'(frame_ready), 0);
      check({tag, " overrun_cnt"}, 32'(overrun_cnt), 0);
      check({tag, " timeout_err"}, 32'(timeout_err), 0);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, " idle"}, 32'(busy), 0);
      tick();
      tick();
   endtask

   task automatic start_frame(input int mx, input int my, output int t0);
      in_mouse_x  = 10'(mx);
      in_mouse_y  = 10'(my);
      frame_start = 1'b1;
      t0 = cyc;
      tick();
      frame_start = 1'b0;
   endtask

   // Full frame with every core answering: each step completes when the slowest
   // core answers, the next step follows one cycle later, then N copy cycles
   // and one swap cycle; frame_ready shows in the cycle after the swap.
   task automatic run_frame(input int mx, input int my, input string tag);
      int t0, big, s, d;
      clear_log();
      start_frame(mx, my, t0);
      wait_idle(400, tag);
      big = 0;
      for (int c = 0; c < CORES; c++) if (lat[c] > big) big = lat[c];
      check({tag, " step count"}, 32'(step_t.size()), RELAX + 1);
      s = t0 + 2;
      d = s + big;
      for (int i = 0; i <= RELAX; i++) begin
         d = s + big;
         if (i < step_t.size()) begin
            check($sformatf("%s step%0d time", tag, i), 32'(step_t[i]), 32'(s));
            check($sformatf("%s step%0d phase", tag, i), 32'(step_ph[i]), (i == 0) ? 0 : 1);
         end
         s = d + 1;
      end
      check({tag, " ready count"}, 32'(ready_t.size()), 1);
      if (ready_t.size() > 0)
         check({tag, " ready time"}, 32'(ready_t[0] - t0), 32'(d + N + 2 - t0));
      check({tag, " mouse_x"}, mouse_x, 32'(mx * 4096));
      check({tag, " mouse_y"}, mouse_y, 32'(my * 4096));
      model_publish();
   endtask

   initial begin
      int t0, pc, next_free, ov;
      int exp_ready[$];

      model_clear();
      // reset values
      reset = 1'b1;
      repeat (3) tick();
      check_zero("reset");
      reset = 1'b0;
      tick();
      drive_nodes(1'b1);
      check_read(7, "pre-frame");
      check_read(0, "pre-frame");

      // directed frame, mouse (100,200), cores answer after 1 cycle
      run_frame(100, 200, "basic");
      check("basic mouse_x const", mouse_x, 32'h0006_4000);
      check("basic mouse_y const", mouse_y, 32'h000C_8000);
      check("basic phase held", 32'(core_phase), 1);
      check_read(7, "basic");
      check_read(0, "basic");
      check_read(19, "basic");
      check_read(20, "basic oob");
      check_read(31, "basic oob");

      // core 2 five cycles late, core 0 double pulse, spurious pulses in ISSUE
      lat[2] = 6;
      dbl0   = 1'b1;
      early  = 1'b1;
      drive_nodes(1'b0);
      run_frame(321, 654, "late");
      check_read(7, "late");
      check_read(12, "late");
      lat[2] = 1;
      dbl0   = 1'b0;
      early  = 1'b0;

      // randomized frames with random latencies and stray pulses while idle
      for (int f = 0; f < 6; f++) begin
         for (int c = 0; c < CORES; c++) lat[c] = $urandom_range(1, 8);
         early = ($urandom_range(0, 1) == 1);
         stray = 1'b1;
         repeat ($urandom_range(2, 6)) tick();
         drive_nodes(1'b0);
         run_frame($urandom_range(0, 1023), $urandom_range(0, 1023), $sformatf("rand%0d", f));
         stray = 1'b0;
         for (int r = 0; r < 3; r++) check_read($urandom_range(0, 31), $sformatf("rand%0d", f));
      end
      early = 1'b0;
      for (int c = 0; c < CORES; c++) lat[c] = 1;

      // core 3 never answers: timeout, no copy, no swap
      lat[3] = -1;
      drive_nodes(1'b0);
      clear_log();
      start_frame(5, 6, t0);
      wait_idle(TMO + 100, "tmo");
      check("tmo step count", 32'(step_t.size()), 1);
      check("tmo err count", 32'(tmo_t.size()), 1);
      if (tmo_t.size() > 0)
         check("tmo err time", 32'(tmo_t[0] - (t0 + 2)), TMO + 1);
      check("tmo no ready", 32'(ready_t.size()), 0);
      check("tmo err", 32'(timeout_err), 1);
      check_read(3, "tmo");
      check_read(17, "tmo");
      lat[3] = 1;

      // overrun: pulses every 10 cycles, then held high until saturation
      drive_nodes(1'b0);
      clear_log();
      exp_ready.delete();
      next_free = cyc;
      ov = 0;
      check("ovr start", 32'(overrun_cnt), 0);
      for (int p = 0; p < 30; p++) begin
         pc = cyc;
         frame_start = 1'b1;
         if (pc >= next_free) begin
            next_free = pc + 31;
            exp_ready.push_back(pc + 31);
         end else if (ov < 255) begin
            ov++;
         end
         tick();
         frame_start = 1'b0;
         check($sformatf("ovr pulse%0d", p), 32'(overrun_cnt), 32'(ov));
         repeat (9) tick();
      end
      frame_start = 1'b1;
      for (int i = 0; i < 400; i++) begin
         pc = cyc;
         if (pc >= next_free) begin
            next_free = pc + 31;
            exp_ready.push_back(pc + 31);
         end else if (ov < 255) begin
            ov++;
         end
         tick();
         if (i % 50 == 49) check($sformatf("ovr held%0d", i), 32'(overrun_cnt), 32'(ov));
      end
      frame_start = 1'b0;
      check("ovr saturated", 32'(overrun_cnt), 255);
      wait_idle(100, "ovr");
      check("ovr ready count", 32'(ready_t.size()), 32'(exp_ready.size()));
      for (int i = 0; i < exp_ready.size() && i < ready_t.size(); i++)
         check($sformatf("ovr ready%0d time", i), 32'(ready_t[i]), 32'(exp_ready[i]));
      model_publish();
      check("ovr tmo sticky", 32'(timeout_err), 1);
      check_read(4, "ovr");
      check_read(18, "ovr");

      // reset in the middle of COPY (node index 5)
      drive_nodes(1'b0);
      clear_log();
      start_frame(77, 88, t0);
      while (cyc < t0 + 15) tick();
      check("rstcopy busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      check_zero("rstcopy");
      tick();
      reset = 1'b0;
      model_clear();
      tick();
      check("rstcopy no ready", 32'(ready_t.size()), 0);
      check_read(7, "rstcopy");
      run_frame(11, 22, "after-rst");
      check_read(7, "after-rst");
      check_read(0, "after-rst");
      check("after-rst ovr", 32'(overrun_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rope_step_scheduler.md
Name: rope_step_scheduler

Overview:
- Per-frame sequencer for the rope physics array (CORES cores × NODES_PER_CORE nodes, 10-bit screen coordinates per node).
- On each frame_start, latches the mouse anchor, then issues one integrate step followed by RELAX_PASSES constraint-relaxation steps, waiting for all cores to acknowledge each step.
- Copies the settled node positions into the back bank of a double-buffered snapshot and swaps banks, so the renderer always reads a complete, consistent frame.

Parameters:
- CORES, 4, number of rope cores.
- NODES_PER_CORE, 5, nodes per core.
- RELAX_PASSES, 3, relaxation steps per frame (≥1).
- TIMEOUT, 1023, maximum cycles to wait for all core_done before aborting the frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per video frame (vsync).
- in_mouse_x  in  10  mouse X in pixels.
- in_mouse_y  in  10  mouse Y in pixels.
- core_done  in  CORES  per-core step-complete pulses.
- nodes_x  in  CORES*NODES_PER_CORE*10  live node X, node k at bits [10k+9:10k].
- nodes_y  in  CORES*NODES_PER_CORE*10  live node Y, same packing.
- core_step  out  1  one-cycle step-issue pulse to all cores.
- core_phase  out  1  0 = integrate, 1 = relax; valid while core_step is high and held until the next issue.
- mouse_x  out  32  latched anchor X, fixed point {10'b0, x, 12'b0}.
- mouse_y  out  32  latched anchor Y, same format.
- rd_idx  in  ceil(log2(N))  renderer node index, N = CORES*NODES_PER_CORE.
- rd_x  out  10  front-bank X of node rd_idx, registered.
- rd_y  out  10  front-bank Y of node rd_idx, registered.
- busy  out  1  high whenever the FSM is not IDLE.
- frame_ready  out  1  one-cycle pulse when a bank swap occurs.
- overrun_cnt  out  8  saturating count of dropped frame_start pulses.
- timeout_err  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset (asynchronous) values:
  - FSM = IDLE.
  - All outputs 0; mouse_x and mouse_y = 0.
  - Both snapshot banks cleared to 0; front bank = 0.
  - pass_cnt, done_seen, timer and copy index = 0.
- A reset asserted mid-frame aborts the frame. No bank swap occurs.
- States: IDLE → LATCH → ISSUE → WAIT → (ISSUE | COPY) → SWAP → IDLE.
- IDLE: frame_start = 1 → LATCH.
- LATCH, 1 cycle:
  - Register the mouse inputs into mouse_x and mouse_y.
  - Clear pass_cnt; set phase = 0.
- ISSUE, 1 cycle:
  - core_step = 1 and core_phase = phase.
  - Clear done_seen and timer.
  - Next state WAIT.
- WAIT:
  - Each cycle: done_seen |= core_done; timer increments.
  - core_done arriving in the ISSUE cycle is ignored. Sampling starts the cycle after core_step.
  - When done_seen is all ones (the cycle the final bit is seen counts):
    - If phase = 0: set phase = 1, pass_cnt = 0, go to ISSUE.
    - If phase = 1 and pass_cnt < RELAX_PASSES-1: increment pass_cnt, go to ISSUE.
    - Otherwise go to COPY.
  - If timer reaches TIMEOUT before completion: set timeout_err, go to IDLE. No copy, no swap.
- COPY: one node per cycle, idx 0..N-1. Write nodes_x/nodes_y slice idx into the back bank (= !front). Takes N cycles.
- SWAP, 1 cycle: toggle front; pulse frame_ready; go to IDLE.
- Frame latency, all cores answering in 1 cycle:
  - 2 + (RELAX_PASSES+1)·2 + N + 1 cycles.
  - Defaults: 2 + 8 + 20 + 1 = 31 cycles.
- Read port: rd_x/rd_y = front_bank[rd_idx], registered, 1-cycle latency.
  - A read in the SWAP cycle returns the old front bank; the new bank is visible from the next read.
  - rd_idx ≥ N returns 0.
- Overrun:
  - frame_start while the FSM is not IDLE is dropped and overrun_cnt increments, saturating at 255.
  - frame_start in the SWAP cycle counts as an overrun.
  - The FSM returns to IDLE regardless.
- Extra core_done pulses in IDLE, LATCH, COPY or SWAP are ignored.

Test Plan:
- Reset, then frame_start with mouse = (100, 200), cores answering 1 cycle after each step:
  - exactly 4 core_step pulses, with phases 0,1,1,1;
  - mouse_x = 0x00064000, mouse_y = 0x000C8000;
  - frame_ready 31 cycles after frame_start.
- Node k driven to x = k+10, y = 2k after a frame: rd_idx = 7 reads (17, 14) one cycle later. Before the first frame all reads return 0.
- Core 2 answers 5 cycles late and core 0 pulses twice: the FSM waits for all bits, and the late answer delays every subsequent issue by 5 cycles.
- Core 3 never answers: timeout_err = 1 exactly TIMEOUT+1 cycles after the step pulse, FSM in IDLE, no frame_ready, front bank unchanged.
- frame_start every 10 cycles for 300 cycles: overrun_cnt increments on each drop and saturates at 255. Completed frames still swap correctly.
- Reset asserted during COPY at idx 5: all outputs return to 0 immediately. The next frame completes normally, with front bank = 1 after the swap.
